// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
// Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  // All segments (including dp) dark, active-high.
  localparam logic [7:0] SEG_OFF = 8'h00;

  // Hex font, entry 15 first so HEX_SEG[n] selects digit n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E D C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // B A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

  // Clock cycles spent on each digit, never less than one.
  function automatic int tick_calc(input int clk_hz, input int refresh_hz, input int digits);
    int t;
    t = clk_hz / (refresh_hz * digits);
    if (t < 1) begin
      t = 1;
    end else begin
      t = t;
    end
    return t;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble/dp/dark to active-high segment pattern {dp,g..a}.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       dark,
  output logic [7:0] seg
);

  // A dark digit turns every segment off, decimal point included.
  always_comb begin
    if (dark) begin
      seg = SEG_OFF;
    end else begin
      seg = {dp, HEX_SEG[nibble]};
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: digit scanning, hex decode,
// leading-zero suppression, PWM dimming, dead time between digits and
// frame-synchronous shadow/active register commit.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 60,
  parameter int BRIGHT_W   = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [DIGITS*4-1:0]   hex_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  lz_en,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic                  busy,
  output logic                  frame_done,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     anode_out
);

  localparam int TICK  = tick_calc(CLK_HZ, REFRESH_HZ, DIGITS);
  localparam int CNT_W = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TICK - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [7:0]        SEG_IDLE   = (ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
  localparam logic [DIGITS-1:0] ANODE_IDLE = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [CNT_W-1:0]    slot_cnt_r;
  logic [IDX_W-1:0]    digit_idx_r;
  logic [BRIGHT_W-1:0] pwm_cnt_r;
  logic                slot_end_s;
  logic                wrap_s;

  logic [DIGITS*4-1:0] sh_hex_r, act_hex_r;
  logic [DIGITS-1:0]   sh_dp_r, act_dp_r;
  logic [DIGITS-1:0]   sh_blank_r, act_blank_r;
  logic                sh_lz_r, act_lz_r;
  logic                busy_r, frame_done_r;

  logic [DIGITS-1:0]   suppress_s;
  logic                run_s;
  logic [3:0]          cur_nib_s;
  logic                cur_dp_s, cur_dark_s;
  logic [7:0]          seg_pat_s;
  logic                anode_en_s;
  logic [DIGITS-1:0]   anode_pat_s;

  assign slot_end_s = (slot_cnt_r == CNT_LAST);
  assign wrap_s     = slot_end_s && (digit_idx_r == IDX_LAST);
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

  // Slot counter and digit index; index advances at the end of each slot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_cnt_r  <= {CNT_W{1'b0}};
      digit_idx_r <= {IDX_W{1'b0}};
    end else if (slot_end_s) begin
      slot_cnt_r <= {CNT_W{1'b0}};
      if (digit_idx_r == IDX_LAST) begin
        digit_idx_r <= {IDX_W{1'b0}};
      end else begin
        digit_idx_r <= digit_idx_r + IDX_W'(1);
      end
    end else begin
      slot_cnt_r <= slot_cnt_r + CNT_W'(1);
    end
  end

  // Free-running PWM phase counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt_r <= {BRIGHT_W{1'b0}};
    end else begin
      pwm_cnt_r <= pwm_cnt_r + BRIGHT_W'(1);
    end
  end

  // Shadow capture and frame-boundary commit; a load on the boundary keeps busy set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sh_hex_r     <= {(DIGITS*4){1'b0}};
      sh_dp_r      <= {DIGITS{1'b0}};
      sh_blank_r   <= {DIGITS{1'b0}};
      sh_lz_r      <= 1'b0;
      act_hex_r    <= {(DIGITS*4){1'b0}};
      act_dp_r     <= {DIGITS{1'b0}};
      act_blank_r  <= {DIGITS{1'b1}};
      act_lz_r     <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= wrap_s;
      if (wrap_s && busy_r) begin
        act_hex_r   <= sh_hex_r;
        act_dp_r    <= sh_dp_r;
        act_blank_r <= sh_blank_r;
        act_lz_r    <= sh_lz_r;
      end
      if (load) begin
        sh_hex_r   <= hex_in;
        sh_dp_r    <= dp_in;
        sh_blank_r <= blank_in;
        sh_lz_r    <= lz_en;
        busy_r     <= 1'b1;
      end else if (wrap_s) begin
        busy_r <= 1'b0;
      end
    end
  end

  // Leading-zero suppression: walk down from the top digit until a nonzero nibble or dp.
  always_comb begin
    suppress_s = {DIGITS{1'b0}};
    run_s      = act_lz_r;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (run_s && (act_hex_r[i*4 +: 4] == 4'h0) && !act_dp_r[i]) begin
        suppress_s[i] = 1'b1;
      end else begin
        run_s = 1'b0;
      end
    end
  end

  // Select the scanned digit's data and work out its anode enable.
  always_comb begin
    cur_nib_s   = act_hex_r[{digit_idx_r, 2'b00} +: 4];
    cur_dp_s    = act_dp_r[digit_idx_r];
    cur_dark_s  = act_blank_r[digit_idx_r] | suppress_s[digit_idx_r];
    anode_en_s  = (slot_cnt_r != {CNT_W{1'b0}}) &&
                  ((brightness == {BRIGHT_W{1'b1}}) || (pwm_cnt_r < brightness));
    anode_pat_s = {DIGITS{1'b0}};
    if (anode_en_s) begin
      anode_pat_s[digit_idx_r] = 1'b1;
    end else begin
      anode_pat_s = {DIGITS{1'b0}};
    end
  end

  seg7_decode u_decode (
    .nibble (cur_nib_s),
    .dp     (cur_dp_s),
    .dark   (cur_dark_s),
    .seg    (seg_pat_s)
  );

  // Registered pin drivers with board polarity applied.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seg_out   <= SEG_IDLE;
      anode_out <= ANODE_IDLE;
    end else if (ACTIVE_LOW != 0) begin
      seg_out   <= ~seg_pat_s;
      anode_out <= ~anode_pat_s;
    end else begin
      seg_out   <= seg_pat_s;
      anode_out <= anode_pat_s;
    end
  end

endmodule
